nibble_packer: RTL
==================

// Module: nibble_packer
// PURPOSE
//   Return path of the nibble selector: collects a stream of 4-bit nibbles, packs NIBBLES of them
//   (most significant nibble first) into one word and delivers the word on output port A or B.
//   Sits between the nibble datapath and the 32-bit DATA_A/DATA_B word domain.
//   Valid/ready on the input and on both outputs; each output holds a one-word register.
// PARAMETERS
//   NIBBLES   8   nibbles per word; word width W = 4*NIBBLES; legal range 2..16
// PORTS
//   CLK        in   1      single clock; all state updates on rising edge
//   RESET      in   1      asynchronous, active-high reset
//   DATA_IN    in   4      input nibble
//   VALID_IN   in   1      DATA_IN/DEST_IN valid
//   DEST_IN    in   1      destination of current word: 0=A, 1=B; sampled on first nibble only
//   READY_IN   out  1      packer accepts a nibble this cycle (VALID_IN & READY_IN = transfer)
//   DATA_A     out  W      packed word for port A
//   VALID_A    out  1      DATA_A holds an undelivered word
//   READY_A    in   1      sink A accepts DATA_A
//   DATA_B     out  W      packed word for port B
//   VALID_B    out  1      DATA_B holds an undelivered word
//   READY_B    in   1      sink B accepts DATA_B
// BEHAVIOUR
//   Reset: state=FILL, nibble count=0, assembly reg=0, DATA_A=DATA_B=0, VALID_A=VALID_B=0, READY_IN=1.
//   Reset asserted mid-word or in HOLD discards partial/held word and both output words.
//   Packing: nibble k (k=0 first) lands in bits [W-1-4k -: 4]; DEST latched with nibble 0.
//   FSM states:
//   - FILL: READY_IN=1. On transfer, count++. On the NIBBLES-th transfer:
//     if target output free (VALID_x=0, or VALID_x=1 & READY_x=1 same cycle), load DATA_x with
//     the completed word, VALID_x=1 next cycle (latency 1 cycle after last nibble), count=0, stay FILL;
//     else go HOLD with completed word.
//   - HOLD: READY_IN=0. When target output free, load it, count=0, return to FILL next cycle.
//   Output x: VALID_x & READY_x clears VALID_x next cycle unless a new word loads that same cycle
//     (back-to-back: VALID_x stays 1, DATA_x takes new word). DATA_x holds its value after drain.
//   A and B drain independently; a word for B never waits on a stalled A.
//   Count wraps from NIBBLES-1 to 0; no partial word is ever emitted (except FLUSH below).
//   VALID_IN ignored while READY_IN=0; DATA_IN/DEST_IN ignored when VALID_IN=0.
// CONFIGURATION
//   NIBBLE_PACKER_FLUSH_EN defined: adds input FLUSH (1 bit). FLUSH=1 in FILL with count>0 and no
//     transfer that cycle: partial word, remaining low nibbles zero-padded, is treated as complete
//     (delivered or HOLD per above). FLUSH with count=0 or in HOLD: no effect. FLUSH coincident with
//     a nibble transfer: nibble is packed first, then flush applies next cycle if still asserted.
//   Not defined: no FLUSH port; only full words are emitted.
// TESTING
//   T1 reset: RESET=1 async mid-clock -> all outputs 0, READY_IN=1 immediately without clock edge.
//   T2 nibbles 0,1,...,7 DEST=0, READY_A=1 -> DATA_A=32'h01234567, VALID_A=1 one cycle after 8th
//      nibble, single cycle pulse; VALID_B stays 0.
//   T3 nibbles 8..F DEST=1 with READY_B=0 -> VALID_B=1, DATA_B=32'h89ABCDEF held; next 8 nibbles
//      A,0,B,1,C,2,D,3 DEST=1 -> READY_IN=0 (HOLD) until READY_B=1, then DATA_B=32'hA0B1C2D3.
//   T4 interleave: word 32'hF9E8D7C6 to A with READY_A=0, then word to B -> B delivered, A still valid.
//   T5 RESET=1 after 5 nibbles, release, send 8 nibbles of 4'h5 -> DATA_A=32'h55555555, no stale data.
//   T6 (FLUSH_EN) nibbles D,F then FLUSH=1 -> DATA_A=32'hDF000000, count=0; FLUSH at count=0 -> no VALID.

Source files
------------

// File: rtl/nibble_packer.sv
// Packs NIBBLES 4-bit nibbles (MS nibble first) into a word and delivers it on port A or B.
// Optional FLUSH input (zero-padded partial word) is enabled by defining NIBBLE_PACKER_FLUSH_EN.
module nibble_packer #(
    parameter int NIBBLES = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
`ifdef NIBBLE_PACKER_FLUSH_EN
    input  logic                 FLUSH,
`endif
    input  logic [3:0]           DATA_IN,
    input  logic                 VALID_IN,
    input  logic                 DEST_IN,
    output logic                 READY_IN,
    output logic [4*NIBBLES-1:0] DATA_A,
    output logic                 VALID_A,
    input  logic                 READY_A,
    output logic [4*NIBBLES-1:0] DATA_B,
    output logic                 VALID_B,
    input  logic                 READY_B
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [W-1:0]   asm_q, asm_d;
    logic           dest_q, dest_d;
    logic [W-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
    logic           valid_a_q, valid_a_d, valid_b_q, valid_b_d;

    logic           xfer, complete, free_a, free_b, last_nibble;
    logic [W-1:0]   base, word;
    logic           word_dest;
    int             idx;

    assign READY_IN = (state_q == FILL);
    assign DATA_A   = data_a_q;
    assign VALID_A  = valid_a_q;
    assign DATA_B   = data_b_q;
    assign VALID_B  = valid_b_q;

    // An output can take a new word if it is empty or is being drained this very cycle.
    assign free_a      = !valid_a_q || READY_A;
    assign free_b      = !valid_b_q || READY_B;
    assign xfer        = VALID_IN && (state_q == FILL);
    assign last_nibble = (count_q == CW'(NIBBLES - 1));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        asm_d     = asm_q;
        dest_d    = dest_q;
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        valid_a_d = valid_a_q && !READY_A;
        valid_b_d = valid_b_q && !READY_B;
        complete  = 1'b0;
        word      = asm_q;
        word_dest = dest_q;
        idx       = W - 1 - 4 * int'(count_q);
        base      = (count_q == '0) ? '0 : asm_q;

        if (xfer) begin
            // Clearing on nibble 0 keeps the unfilled low nibbles zero for a flushed word.
            base[idx -: 4] = DATA_IN;
            word      = base;
            word_dest = (count_q == '0) ? DEST_IN : dest_q;
            asm_d     = base;
            dest_d    = word_dest;
            if (last_nibble) begin
                complete = 1'b1;
                count_d  = '0;
            end else begin
                count_d  = count_q + CW'(1);
            end
        end
`ifdef NIBBLE_PACKER_FLUSH_EN
        else if (state_q == FILL && FLUSH && count_q != '0) begin
            complete = 1'b1;
            count_d  = '0;
        end
`endif

        if (state_q == HOLD) begin
            complete = 1'b1;
        end

        if (complete) begin
            if (!word_dest && free_a) begin
                data_a_d  = word;
                valid_a_d = 1'b1;
                state_d   = FILL;
            end else if (word_dest && free_b) begin
                data_b_d  = word;
                valid_b_d = 1'b1;
                state_d   = FILL;
            end else begin
                state_d   = HOLD;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= FILL;
            count_q   <= '0;
            asm_q     <= '0;
            dest_q    <= 1'b0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            asm_q     <= asm_d;
            dest_q    <= dest_d;
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end
endmodule
